// File: rtl/shift_signal_shifter_32.sv
// One-cycle 32-bit barrel shifter: shamt is decoded one-hot, and the result is an OR of masked per-position candidates.
// Optional feature: define SHIFTER_SRA_EN to enable arithmetic right shift (sign fill from din[31]).
module shift_signal_shifter_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [4:0]  shamt,
    input  logic        right,
    input  logic        arith,
    input  logic [31:0] din,
    output logic [31:0] shift,
    output logic [31:0] dout,
    output logic        out_valid
);

    logic [31:0] s32;
    logic [31:0] result;
    logic        fill;
    logic [31:0] acc [0:32];

    logic [31:0] shift_q, shift_d;
    logic [31:0] dout_q,  dout_d;
    logic        valid_q, valid_d;

`ifdef SHIFTER_SRA_EN
    assign fill = arith & din[31];
`else
    logic unused_arith;
    assign unused_arith = arith;
    assign fill         = 1'b0;
`endif

    assign acc[0] = 32'h0;

    genvar gk;
    generate
        for (gk = 0; gk < 32; gk++) begin : g_pos
            logic [31:0] left_c;
            logic [31:0] right_c;
            logic [31:0] cand;

            assign s32[gk] = (shamt == 5'(gk));

            if (gk == 0) begin : g_zero
                assign left_c  = din;
                assign right_c = din;
            end else begin : g_nz
                assign left_c  = {din[31-gk:0], {gk{1'b0}}};
                assign right_c = {{gk{fill}}, din[31:gk]};
            end

            assign cand        = right ? right_c : left_c;
            // Only the position whose decode bit is set contributes to the OR.
            assign acc[gk + 1] = acc[gk] | (cand & {32{s32[gk]}});
        end
    endgenerate

    assign result = acc[32];

    always_comb begin
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        if (in_valid) begin
            shift_d = s32;
            dout_d  = result;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= 32'h0000_0001;
            dout_q  <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign shift     = shift_q;
    assign dout      = dout_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_shift_signal_shifter_32.sv
// Directed bench for shift_signal_shifter_32; expectations follow SHIFTER_SRA_EN when it is defined.
module tb_shift_signal_shifter_32;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [4:0]  shamt;
    logic        right;
    logic        arith;
    logic [31:0] din;
    logic [31:0] shift;
    logic [31:0] dout;
    logic        out_valid;

    int n_cmp = 0;
    int n_err = 0;

    shift_signal_shifter_32 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .shamt     (shamt),
        .right     (right),
        .arith     (arith),
        .din       (din),
        .shift     (shift),
        .dout      (dout),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one transaction just after an edge, then sample just after the next edge.
    task automatic xfer(input string tag, input logic [4:0] sa, input logic r, input logic a,
                        input logic [31:0] d, input logic [31:0] exp_dout, input logic [31:0] exp_shift);
        in_valid = 1'b1;
        shamt    = sa;
        right    = r;
        arith    = a;
        din      = d;
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, {31'b0, out_valid}, 32'h1);
        chk({tag, ".dout"},  dout,  exp_dout);
        chk({tag, ".shift"}, shift, exp_shift);
    endtask

    logic [31:0] pat;
    logic [31:0] held;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        shamt    = 5'd0;
        right    = 1'b0;
        arith    = 1'b0;
        din      = 32'h0;
        pat      = 32'h8FFF_FFFF;

        #2;
        chk("rst.dout",  dout,  32'h0);
        chk("rst.shift", shift, 32'h0000_0001);
        chk("rst.valid", {31'b0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Right logical sweep, back-to-back (in_valid stays high).
        for (int k = 0; k < 32; k++)
            xfer($sformatf("srl%0d", k), 5'(k), 1'b1, 1'b0, pat, pat >> k, 32'h1 << k);
        in_valid = 1'b0;

        xfer("srl0_spot",  5'd0,  1'b1, 1'b0, 32'h8FFF_FFFF, 32'h8FFF_FFFF, 32'h0000_0001);
        xfer("srl4_spot",  5'd4,  1'b1, 1'b0, 32'h8FFF_FFFF, 32'h08FF_FFFF, 32'h0000_0010);
        xfer("srl31_spot", 5'd31, 1'b1, 1'b0, 32'h8FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
        xfer("sll4",       5'd4,  1'b0, 1'b0, 32'h8FFF_FFFF, 32'hFFFF_FFF0, 32'h0000_0010);
        xfer("sll31",      5'd31, 1'b0, 1'b0, 32'h8FFF_FFFF, 32'h8000_0000, 32'h8000_0000);
        xfer("sll31b",     5'd31, 1'b0, 1'b0, 32'h1234_5679, 32'h8000_0000, 32'h8000_0000);
        xfer("sll0",       5'd0,  1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0001);
        xfer("sll4_arith", 5'd4,  1'b0, 1'b1, 32'h8FFF_FFFF, 32'hFFFF_FFF0, 32'h0000_0010);
        xfer("sll8",       5'd8,  1'b0, 1'b0, 32'h0001_00FF, 32'h0100_FF00, 32'h0000_0100);
        xfer("dec5",       5'd5,  1'b0, 1'b0, 32'h0000_0001, 32'h0000_0020, 32'h0000_0020);
        xfer("srl16",      5'd16, 1'b1, 1'b0, 32'hA5A5_1234, 32'h0000_A5A5, 32'h0001_0000);
`ifdef SHIFTER_SRA_EN
        xfer("sra4",  5'd4,  1'b1, 1'b1, 32'h8FFF_FFFF, 32'hF8FF_FFFF, 32'h0000_0010);
        xfer("sra31", 5'd31, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        xfer("sra4p", 5'd4,  1'b1, 1'b1, 32'h7000_0000, 32'h0700_0000, 32'h0000_0010);
`else
        xfer("sra4",  5'd4,  1'b1, 1'b1, 32'h8FFF_FFFF, 32'h08FF_FFFF, 32'h0000_0010);
        xfer("sra31", 5'd31, 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000);
        xfer("sra4p", 5'd4,  1'b1, 1'b1, 32'h7000_0000, 32'h0700_0000, 32'h0000_0010);
`endif

        // Hold: in_valid low, inputs wiggle between edges; outputs keep last result.
        in_valid = 1'b0;
        din      = 32'hFFFF_FFFF;
        shamt    = 5'd3;
        right    = 1'b0;
        @(posedge clk);
        #1;
        chk("hold.valid", {31'b0, out_valid}, 32'h0);
        chk("hold.dout",  dout,  32'h0700_0000);
        chk("hold.shift", shift, 32'h0000_0010);
        #2 din = 32'h0;
        #1;
        chk("hold_mid.dout", dout, 32'h0700_0000);

        // Reset between edges while a result is valid.
        xfer("pre_rst", 5'd2, 1'b0, 1'b0, 32'h0000_0003, 32'h0000_000C, 32'h0000_0004);
        in_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("mrst.dout",  dout,  32'h0);
        chk("mrst.shift", shift, 32'h0000_0001);
        chk("mrst.valid", {31'b0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        held  = dout;
        @(posedge clk);
        #1;
        chk("post_rst_hold.valid", {31'b0, out_valid}, 32'h0);
        chk("post_rst_hold.dout",  dout, 32'h0);
        chk("post_rst_hold.same",  dout, held);
        xfer("post_rst", 5'd1, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0008, 32'h0000_0002);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("final.valid", {31'b0, out_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
